// File: rtl/block_color_mapper_if.sv
// Palette write channel of the block colour mapper: valid/ready handshake
// carrying a 4-bit palette index and a 24-bit {R,G,B} value.
interface block_color_mapper_if;
  logic        pal_wr_valid;
  logic [3:0]  pal_wr_idx;
  logic [23:0] pal_wr_rgb;
  logic        pal_wr_ready;

  modport master (
    output pal_wr_valid,
    output pal_wr_idx,
    output pal_wr_rgb,
    input  pal_wr_ready
  );

  modport slave (
    input  pal_wr_valid,
    input  pal_wr_idx,
    input  pal_wr_rgb,
    output pal_wr_ready
  );
endinterface

// File: rtl/block_color_mapper.sv
// Maps sprite colour indices through a 16x24 programmable palette to registered VGA RGB.
// After reset an init FSM loads a grey ramp before palette writes and pixels are enabled.
module block_color_mapper #(
  parameter int unsigned SRC_LAT         = 1,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'd0,
  parameter logic [23:0] BG_RGB          = 24'h000040
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [3:0]                  colorIndex,
  input  logic                        drawBlock,
  input  logic                        blank,
  block_color_mapper_if.slave         pal,
  output logic                        init_done,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state, state_next;
  logic [3:0]    init_cnt;
  logic          run_q;
  logic          init_we;
  logic          user_we;
  logic [23:0]   palette [16];
  logic [SRC_LAT-1:0] db_dly;
  logic [SRC_LAT-1:0] bl_dly;
  logic          db_al;
  logic          bl_al;
  logic [23:0]   rgb_q;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT)
        init_cnt <= init_cnt + 4'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_cnt == 4'd15) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Output decode
  always_comb begin
    init_we = 1'b0;
    user_we = 1'b0;
    case (state)
      ST_INIT: init_we = 1'b1;
      ST_RUN:  user_we = pal.pal_wr_valid & run_q;
      default: ;
    endcase
  end

  // Ready/done are registered from the next state so they rise with the first RUN cycle
  always_ff @(posedge Clk) begin
    if (!Reset)
      run_q <= 1'b0;
    else
      run_q <= (state_next == ST_RUN);
  end

  assign pal.pal_wr_ready = run_q;
  assign init_done        = run_q;

  // Palette is not reset; INIT rewrites every entry. Entry n gets 8'h11*n, i.e. {n,n} per channel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (init_we)
        palette[init_cnt] <= {3{init_cnt, init_cnt}};
      else if (user_we)
        palette[pal.pal_wr_idx] <= pal.pal_wr_rgb;
    end
  end

  // Stage 1: realign drawBlock/blank with the sprite RAM read
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      db_dly <= '0;
      bl_dly <= '0;
    end else begin
      db_dly[0] <= drawBlock;
      bl_dly[0] <= blank;
      for (int unsigned i = 1; i < SRC_LAT; i++) begin
        db_dly[i] <= db_dly[i-1];
        bl_dly[i] <= bl_dly[i-1];
      end
    end
  end

  assign db_al = db_dly[SRC_LAT-1];
  assign bl_al = bl_dly[SRC_LAT-1];

  // Stage 2: palette read sees the pre-write entry when a write lands on the same edge
  always_ff @(posedge Clk) begin
    if (!Reset)
      rgb_q <= '0;
    else if (!run_q || !bl_al)
      rgb_q <= '0;
    else if (!db_al || colorIndex == TRANSPARENT_IDX)
      rgb_q <= BG_RGB;
    else
      rgb_q <= palette[colorIndex];
  end

  assign VGA_R = rgb_q[23:16];
  assign VGA_G = rgb_q[15:8];
  assign VGA_B = rgb_q[7:0];

endmodule
